// File: rtl/imem_responder_pkg.sv
// rtl/imem_responder_pkg.sv - memory protocol types and responder defaults
package imem_responder_pkg;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic [31:0] mem_rdata;
    logic        mem_ready;
  } mem_out_type;

  localparam int default_mem_depth   = 10;
  localparam int default_wait_states = 1;

endpackage

// File: rtl/imem_responder_sram_array.sv
// rtl/imem_responder_sram_array.sv - single-port sync RAM, byte write enables, registered read
module sram_array #(
  parameter int mem_depth = 10
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic [3:0]           we,
  input  logic [mem_depth-1:0] addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  logic [31:0] mem [2**mem_depth];

  // Read data only updates on a pure read, so it holds through any wait states.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      if (we == 4'b0000) rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - memory-side responder with configurable wait states
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int mem_depth   = default_mem_depth,
  parameter int wait_states = default_wait_states
) (
  input  logic        clk,
  input  logic        rst,
  input  mem_in_type  mem_in,
  output mem_out_type mem_out
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] wait_load = 4'((wait_states == 0) ? 0 : wait_states - 1);

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        capture;
  logic        rd_q;
  logic [3:0]  ram_we;
  logic [31:0] ram_rdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      rd_q  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (capture) rd_q <= !mem_in.mem_fence && (mem_in.mem_wstrb == 4'b0000);
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    case (state)
      IDLE, RESP: begin
        if (rst && mem_in.mem_valid) begin
          capture = 1'b1;
          if (wait_states == 0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = wait_load;
          end
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_next = RESP;
        else             cnt_next   = cnt - 4'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Fence suppresses the array access entirely, even with strobes set.
  assign ram_we = mem_in.mem_fence ? 4'b0000 : mem_in.mem_wstrb;

  sram_array #(.mem_depth(mem_depth)) u_ram (
    .clk   (clk),
    .en    (capture && !mem_in.mem_fence),
    .we    (ram_we),
    .addr  (mem_in.mem_addr[mem_depth+1:2]),
    .wdata (mem_in.mem_wdata),
    .rdata (ram_rdata)
  );

  assign mem_out.mem_ready = (state == RESP);
  assign mem_out.mem_rdata = ((state == RESP) && rd_q) ? ram_rdata : 32'd0;

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - scoreboard bench for imem_responder at wait_states 0, 1 and 3
module tb_imem_responder;
  import imem_responder_pkg::*;

  localparam int n_dut = 3;
  localparam int ws_tab [n_dut] = '{0, 1, 3};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  mem_in_type  mem_in_a  [n_dut];
  mem_out_type mem_out_a [n_dut];

  logic [31:0] model [n_dut][1024];
  logic [31:0] exp_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < n_dut; g++) begin : g_dut
    imem_responder #(.mem_depth(10), .wait_states(ws_tab[g])) u_dut (
      .clk     (clk),
      .rst     (rst),
      .mem_in  (mem_in_a[g]),
      .mem_out (mem_out_a[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic idle(input int d);
    mem_in_a[d] = '0;
  endtask

  // Presents one request and waits for its response; leaves it driven so a
  // following call lands in the RESP cycle and exercises back-to-back capture.
  task automatic xfer(input int d, input string tag, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] wstrb, input logic fence);
    logic [31:0] e, w, got;
    int          cyc;
    mem_in_a[d] = '{mem_valid: 1'b1, mem_fence: fence, mem_instr: 1'b0,
                    mem_addr: addr, mem_wdata: wdata, mem_wstrb: wstrb};
    w = model[d][addr[11:2]];
    if (fence || wstrb != 4'b0000) begin
      e = 32'd0;
      if (!fence)
        for (int i = 0; i < 4; i++)
          if (wstrb[i]) w[8*i +: 8] = wdata[8*i +: 8];
      model[d][addr[11:2]] = w;
    end else begin
      e = w;
    end
    exp_q.push_back(e);
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (!mem_out_a[d].mem_ready && cyc < 40);
    got = mem_out_a[d].mem_rdata;
    e = exp_q.pop_front();
    check({tag, "_lat"}, 32'(cyc), 32'(ws_tab[d] + 1));
    check({tag, "_data"}, got, e);
  endtask

  initial begin
    int pulses;
    for (int d = 0; d < n_dut; d++) begin
      idle(d);
      for (int i = 0; i < 1024; i++) model[d][i] = 32'h1000_0000 + 32'(i);
    end
    for (int i = 0; i < 1024; i++) begin
      g_dut[0].u_dut.u_ram.mem[i] = 32'h1000_0000 + 32'(i);
      g_dut[1].u_dut.u_ram.mem[i] = 32'h1000_0000 + 32'(i);
      g_dut[2].u_dut.u_ram.mem[i] = 32'h1000_0000 + 32'(i);
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < n_dut; d++) begin
      check("rst_ready", 32'(mem_out_a[d].mem_ready), 32'd0);
      check("rst_rdata", mem_out_a[d].mem_rdata, 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);

    xfer(1, "wr_beef", 32'h100, 32'hDEADBEEF, 4'hF, 1'b0);
    idle(1); @(negedge clk);
    xfer(1, "rd_beef", 32'h100, 32'h0, 4'h0, 1'b0);
    idle(1); @(negedge clk);

    xfer(1, "wr_ones", 32'h40, 32'hFFFFFFFF, 4'hF, 1'b0);
    xfer(1, "wr_strb", 32'h40, 32'h11223344, 4'h5, 1'b0);
    xfer(1, "rd_strb", 32'h40, 32'h0, 4'h0, 1'b0);
    idle(1); @(negedge clk);
    check("strb_word", model[1][16], 32'hFF22FF44);

    for (int i = 0; i < 8; i++) xfer(0, "stream", 32'(4 * i), 32'h0, 4'h0, 1'b0);
    idle(0); @(negedge clk);
    check("stream_end_ready", 32'(mem_out_a[0].mem_ready), 32'd0);

    xfer(1, "alias_wr", 32'h1004, 32'hA5A5A5A5, 4'hF, 1'b0);
    xfer(1, "alias_rd4", 32'h0004, 32'h0, 4'h0, 1'b0);
    xfer(1, "alias_rd6", 32'h0006, 32'h0, 4'h0, 1'b0);
    idle(1); @(negedge clk);

    xfer(1, "fence", 32'h20, 32'h12345678, 4'hF, 1'b1);
    xfer(1, "fence_rd", 32'h20, 32'h0, 4'h0, 1'b0);
    idle(1); @(negedge clk);
    check("fence_old", model[1][8], 32'h1000_0008);

    xfer(2, "ws3_wr", 32'h80, 32'hCAFEF00D, 4'hF, 1'b0);
    mem_in_a[2] = '{mem_valid: 1'b1, mem_fence: 1'b0, mem_instr: 1'b1,
                    mem_addr: 32'h80, mem_wdata: 32'h0, mem_wstrb: 4'h0};
    @(posedge clk);
    @(negedge clk);
    idle(2);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      if (mem_out_a[2].mem_ready) pulses++;
    end
    check("rst_abandon", 32'(pulses), 32'd0);
    xfer(2, "ws3_rd", 32'h80, 32'h0, 4'h0, 1'b1 == 1'b0);
    idle(2); @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
